// File: rtl/agu_nd_multi.sv
// -----------------------------------------------------------------------------
// agu_nd_multi
//   Multi-channel 2-D address generator. Each channel walks an inner loop of
//   ILEN elements spaced by STRIDE, then moves to the next of OLEN rows spaced
//   by PITCH (row base to row base). After the final element the channel
//   returns to START and pulses wrap for one cycle. A jump sets the address to
//   START + offset without disturbing the loop counters. All address arithmetic
//   is modulo 2^ADDR_WIDTH. A length field of 0 behaves as 1.
//
// Ports (channel c occupies bits [c*W +: W] of every packed bus):
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active-high
//   cfg_load   : per channel, latch cfg_* fields and restart the pattern
//   cfg_start  : per channel start address
//   cfg_stride : per channel inner-loop increment
//   cfg_pitch  : per channel row-to-row increment
//   cfg_ilen   : per channel inner length
//   cfg_olen   : per channel outer length
//   step_en    : per channel, advance one element
//   jump_en    : per channel, addr <= start + jump_off
//   jump_off   : per channel jump offset
//   addr       : per channel current address (registered)
//   last       : per channel, current address is the final element
//   wrap       : per channel one-cycle pulse after a pattern-completing step
// -----------------------------------------------------------------------------
module agu_nd_multi #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              cfg_load,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   cfg_start,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   cfg_stride,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   cfg_pitch,
  input  logic [NUM_CH*CNT_WIDTH-1:0]    cfg_ilen,
  input  logic [NUM_CH*CNT_WIDTH-1:0]    cfg_olen,
  input  logic [NUM_CH-1:0]              step_en,
  input  logic [NUM_CH-1:0]              jump_en,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   jump_off,
  output logic [NUM_CH*ADDR_WIDTH-1:0]   addr,
  output logic [NUM_CH-1:0]              last,
  output logic [NUM_CH-1:0]              wrap
);

  localparam int AW = ADDR_WIDTH;
  localparam int CW = CNT_WIDTH;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [AW-1:0] start_q,    start_d;
      logic [AW-1:0] stride_q,   stride_d;
      logic [AW-1:0] pitch_q,    pitch_d;
      logic [AW-1:0] row_base_q, row_base_d;
      logic [AW-1:0] addr_q,     addr_d;
      logic [CW-1:0] ilen_q,     ilen_d;
      logic [CW-1:0] olen_q,     olen_d;
      logic [CW-1:0] icnt_q,     icnt_d;
      logic [CW-1:0] ocnt_q,     ocnt_d;
      logic          wrap_q,     wrap_d;

      logic [CW-1:0] ilast;
      logic [CW-1:0] olast;
      logic          row_end;
      logic          pat_end;
      logic [AW-1:0] next_row;

      // Terminal counter values; a zero length collapses to a single element.
      assign ilast    = (ilen_q == '0) ? '0 : ilen_q - CNT_ONE;
      assign olast    = (olen_q == '0) ? '0 : olen_q - CNT_ONE;
      assign row_end  = (icnt_q == ilast);
      assign pat_end  = row_end && (ocnt_q == olast);
      assign next_row = row_base_q + pitch_q;

      always_comb begin
        start_d    = start_q;
        stride_d   = stride_q;
        pitch_d    = pitch_q;
        ilen_d     = ilen_q;
        olen_d     = olen_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        icnt_d     = icnt_q;
        ocnt_d     = ocnt_q;
        // wrap is a pulse: cleared unless this cycle performs a wrapping step
        wrap_d     = 1'b0;

        if (cfg_load[gi]) begin
          start_d    = cfg_start[gi*AW +: AW];
          stride_d   = cfg_stride[gi*AW +: AW];
          pitch_d    = cfg_pitch[gi*AW +: AW];
          ilen_d     = cfg_ilen[gi*CW +: CW];
          olen_d     = cfg_olen[gi*CW +: CW];
          row_base_d = cfg_start[gi*AW +: AW];
          addr_d     = cfg_start[gi*AW +: AW];
          icnt_d     = '0;
          ocnt_d     = '0;
        end else if (jump_en[gi]) begin
          // Counters and row base stay put so later steps resume the walk
          // relative to the jumped address.
          addr_d = start_q + jump_off[gi*AW +: AW];
        end else if (step_en[gi]) begin
          if (!row_end) begin
            icnt_d = icnt_q + CNT_ONE;
            addr_d = addr_q + stride_q;
          end else if (!pat_end) begin
            icnt_d     = '0;
            ocnt_d     = ocnt_q + CNT_ONE;
            row_base_d = next_row;
            addr_d     = next_row;
          end else begin
            icnt_d     = '0;
            ocnt_d     = '0;
            row_base_d = start_q;
            addr_d     = start_q;
            wrap_d     = 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          start_q    <= '0;
          stride_q   <= '0;
          pitch_q    <= '0;
          ilen_q     <= '0;
          olen_q     <= '0;
          row_base_q <= '0;
          addr_q     <= '0;
          icnt_q     <= '0;
          ocnt_q     <= '0;
          wrap_q     <= 1'b0;
        end else begin
          start_q    <= start_d;
          stride_q   <= stride_d;
          pitch_q    <= pitch_d;
          ilen_q     <= ilen_d;
          olen_q     <= olen_d;
          row_base_q <= row_base_d;
          addr_q     <= addr_d;
          icnt_q     <= icnt_d;
          ocnt_q     <= ocnt_d;
          wrap_q     <= wrap_d;
        end
      end

      assign addr[gi*AW +: AW] = addr_q;
      assign last[gi]          = pat_end;
      assign wrap[gi]          = wrap_q;
    end
  endgenerate

endmodule

// File: tb/tb_agu_nd_multi.sv
// -----------------------------------------------------------------------------
// tb_agu_nd_multi
//   Directed scenarios plus randomized multi-channel traffic for agu_nd_multi.
//   The reference model tracks each channel as a linear element index k within
//   an ILEN*OLEN pattern and derives the address arithmetically from it.
// -----------------------------------------------------------------------------
module tb_agu_nd_multi;

  localparam int NUM_CH = 4;
  localparam int AW     = 14;
  localparam int CW     = 11;
  localparam int AMASK  = (1 << AW) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_CH-1:0]    cfg_load = '0;
  logic [NUM_CH*AW-1:0] cfg_start = '0;
  logic [NUM_CH*AW-1:0] cfg_stride = '0;
  logic [NUM_CH*AW-1:0] cfg_pitch = '0;
  logic [NUM_CH*CW-1:0] cfg_ilen = '0;
  logic [NUM_CH*CW-1:0] cfg_olen = '0;
  logic [NUM_CH-1:0]    step_en = '0;
  logic [NUM_CH-1:0]    jump_en = '0;
  logic [NUM_CH*AW-1:0] jump_off = '0;
  logic [NUM_CH*AW-1:0] addr;
  logic [NUM_CH-1:0]    last;
  logic [NUM_CH-1:0]    wrap;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_start [NUM_CH];
  int m_stride[NUM_CH];
  int m_pitch [NUM_CH];
  int m_ilen  [NUM_CH];
  int m_olen  [NUM_CH];
  int m_k     [NUM_CH];
  int m_addr  [NUM_CH];
  bit m_wrap  [NUM_CH];

  agu_nd_multi #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_start (cfg_start),
    .cfg_stride(cfg_stride),
    .cfg_pitch (cfg_pitch),
    .cfg_ilen  (cfg_ilen),
    .cfg_olen  (cfg_olen),
    .step_en   (step_en),
    .jump_en   (jump_en),
    .jump_off  (jump_off),
    .addr      (addr),
    .last      (last),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic int eff(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic int get_addr(input int c);
    return int'(addr[c*AW +: AW]);
  endfunction

  function automatic bit model_last(input int c);
    return m_k[c] == eff(m_ilen[c]) * eff(m_olen[c]) - 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_start[c] = 0; m_stride[c] = 0; m_pitch[c] = 0;
      m_ilen[c] = 0; m_olen[c] = 0; m_k[c] = 0; m_addr[c] = 0; m_wrap[c] = 0;
    end
  endtask

  // Applies the inputs currently driven to the model, as the next edge will.
  task automatic model_apply();
    int il, n, k1;
    for (int c = 0; c < NUM_CH; c++) begin
      m_wrap[c] = 0;
      if (cfg_load[c]) begin
        m_start[c]  = int'(cfg_start[c*AW +: AW]);
        m_stride[c] = int'(cfg_stride[c*AW +: AW]);
        m_pitch[c]  = int'(cfg_pitch[c*AW +: AW]);
        m_ilen[c]   = int'(cfg_ilen[c*CW +: CW]);
        m_olen[c]   = int'(cfg_olen[c*CW +: CW]);
        m_k[c]      = 0;
        m_addr[c]   = m_start[c];
      end else if (jump_en[c]) begin
        m_addr[c] = (m_start[c] + int'(jump_off[c*AW +: AW])) & AMASK;
      end else if (step_en[c]) begin
        il = eff(m_ilen[c]);
        n  = il * eff(m_olen[c]);
        k1 = m_k[c] + 1;
        if (k1 == n) begin
          m_k[c] = 0; m_addr[c] = m_start[c]; m_wrap[c] = 1;
        end else if (k1 % il == 0) begin
          m_k[c] = k1;
          m_addr[c] = (m_start[c] + (k1 / il) * m_pitch[c]) & AMASK;
        end else begin
          m_k[c] = k1;
          m_addr[c] = (m_addr[c] + m_stride[c]) & AMASK;
        end
      end
    end
  endtask

  task automatic tick();
    model_apply();
    @(posedge clk);
    #1;
    cfg_load = '0;
    jump_en  = '0;
    step_en  = '0;
  endtask

  task automatic set_cfg(input int c, input int st, input int sd, input int pt,
                         input int il, input int ol);
    cfg_start[c*AW +: AW]  = st[AW-1:0];
    cfg_stride[c*AW +: AW] = sd[AW-1:0];
    cfg_pitch[c*AW +: AW]  = pt[AW-1:0];
    cfg_ilen[c*CW +: CW]   = il[CW-1:0];
    cfg_olen[c*CW +: CW]   = ol[CW-1:0];
  endtask

  task automatic test_reset();
    logic [NUM_CH-1:0] ones;
    ones = '1;
    rst = 1'b1;
    #3;
    checks++;
    if (addr !== '0 || wrap !== '0 || last !== ones) begin
      errors++;
      $display("FAIL reset_init: addr=%h wrap=%b last=%b, expected addr=0 wrap=0 last=%b",
               addr, wrap, last, ones);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    $display("reset: initial values checked");

    // walk channel 0 to a wrap, then reset between edges
    set_cfg(0, 'h55, 1, 0, 2, 1);
    cfg_load[0] = 1'b1; tick();
    step_en[0] = 1'b1; tick();
    step_en[0] = 1'b1; tick();
    checks++;
    if (wrap[0] !== 1'b1 || get_addr(0) !== 'h55) begin
      errors++;
      $display("FAIL reset_prewalk: wrap=%b addr=%h, expected wrap=1 addr=0055",
               wrap[0], get_addr(0));
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (addr !== '0 || wrap !== '0 || last !== ones) begin
      errors++;
      $display("FAIL reset_async: addr=%h wrap=%b last=%b, expected addr=0 wrap=0 last=%b",
               addr, wrap, last, ones);
    end
    $display("reset: asynchronous mid-walk reset checked");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_1d();
    int exp_a[4] = '{'h101, 'h102, 'h103, 'h100};
    bit exp_w[4] = '{0, 0, 0, 1};
    bit exp_l[4] = '{0, 0, 1, 0};
    int wraps = 0;
    set_cfg(0, 'h100, 1, 0, 4, 1);
    cfg_load[0] = 1'b1; tick();
    checks++;
    if (get_addr(0) !== 'h100 || last[0] !== 1'b0 || wrap[0] !== 1'b0) begin
      errors++;
      $display("FAIL 1d_load: addr=%h last=%b wrap=%b, expected addr=0100 last=0 wrap=0",
               get_addr(0), last[0], wrap[0]);
    end
    for (int i = 0; i < 4; i++) begin
      step_en[0] = 1'b1; tick();
      wraps += int'(wrap[0]);
      checks++;
      if (get_addr(0) !== exp_a[i] || wrap[0] !== exp_w[i] || last[0] !== exp_l[i]) begin
        errors++;
        $display("FAIL 1d_step%0d: addr=%h wrap=%b last=%b, expected addr=%h wrap=%b last=%b",
                 i, get_addr(0), wrap[0], last[0], exp_a[i], exp_w[i], exp_l[i]);
      end
      $display("1d: step %0d addr=%h wrap=%b last=%b", i, get_addr(0), wrap[0], last[0]);
    end
    tick();
    wraps += int'(wrap[0]);
    checks++;
    if (wraps !== 1) begin
      errors++;
      $display("FAIL 1d_wrapcount: saw %0d wrap pulses, expected 1", wraps);
    end
  endtask

  task automatic test_2d();
    int exp_a[6] = '{'h12, 'h14, 'h50, 'h52, 'h54, 'h10};
    set_cfg(1, 'h10, 2, 'h40, 3, 2);
    cfg_load[1] = 1'b1; tick();
    for (int i = 0; i < 6; i++) begin
      step_en[1] = 1'b1; tick();
      checks++;
      if (get_addr(1) !== exp_a[i] || wrap[1] !== (i == 5) || last[1] !== (i == 4)) begin
        errors++;
        $display("FAIL 2d_step%0d: addr=%h wrap=%b last=%b, expected addr=%h wrap=%b last=%b",
                 i, get_addr(1), wrap[1], last[1], exp_a[i], (i == 5), (i == 4));
      end
      $display("2d: step %0d addr=%h wrap=%b last=%b", i, get_addr(1), wrap[1], last[1]);
    end
  endtask

  task automatic test_priority();
    set_cfg(2, 'h200, 5, 'h100, 3, 2);
    cfg_load[2] = 1'b1; tick();
    step_en[2] = 1'b1; tick();
    checks++;
    if (get_addr(2) !== 'h205) begin
      errors++;
      $display("FAIL prio_prestep: addr=%h, expected 0205", get_addr(2));
    end
    set_cfg(2, 'h300, 5, 'h100, 3, 2);
    jump_off[2*AW +: AW] = 14'h077;
    cfg_load[2] = 1'b1; jump_en[2] = 1'b1; step_en[2] = 1'b1; tick();
    checks++;
    if (get_addr(2) !== 'h300 || wrap[2] !== 1'b0) begin
      errors++;
      $display("FAIL prio_load: addr=%h wrap=%b, expected addr=0300 wrap=0", get_addr(2), wrap[2]);
    end
    $display("priority: load+jump+step addr=%h", get_addr(2));
    step_en[2] = 1'b1; tick();
    jump_off[2*AW +: AW] = 14'h020;
    jump_en[2] = 1'b1; step_en[2] = 1'b1; tick();
    checks++;
    if (get_addr(2) !== 'h320 || last[2] !== 1'b0) begin
      errors++;
      $display("FAIL prio_jump: addr=%h last=%b, expected addr=0320 last=0", get_addr(2), last[2]);
    end
    $display("priority: jump+step addr=%h", get_addr(2));
    step_en[2] = 1'b1; tick();
    checks++;
    if (get_addr(2) !== 'h325) begin
      errors++;
      $display("FAIL prio_after_jump: addr=%h, expected 0325", get_addr(2));
    end
    step_en[2] = 1'b1; tick();
    checks++;
    if (get_addr(2) !== 'h400) begin
      errors++;
      $display("FAIL prio_rowstep: addr=%h, expected 0400", get_addr(2));
    end
    step_en[2] = 1'b1; tick();
    step_en[2] = 1'b1; tick();
    checks++;
    if (get_addr(2) !== 'h40A || last[2] !== 1'b1) begin
      errors++;
      $display("FAIL prio_last: addr=%h last=%b, expected addr=040a last=1", get_addr(2), last[2]);
    end
    // a jump on the final element suppresses the wrapping step
    jump_off[2*AW +: AW] = 14'h011;
    jump_en[2] = 1'b1; step_en[2] = 1'b1; tick();
    checks++;
    if (get_addr(2) !== 'h311 || wrap[2] !== 1'b0 || last[2] !== 1'b1) begin
      errors++;
      $display("FAIL prio_jump_at_end: addr=%h wrap=%b last=%b, expected addr=0311 wrap=0 last=1",
               get_addr(2), wrap[2], last[2]);
    end
    $display("priority: jump at final element addr=%h wrap=%b", get_addr(2), wrap[2]);
  endtask

  task automatic test_overflow();
    set_cfg(3, 'h3FFE, 3, 0, 2, 1);
    cfg_load[3] = 1'b1; tick();
    step_en[3] = 1'b1; tick();
    checks++;
    if (get_addr(3) !== 'h0001 || last[3] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_step: addr=%h last=%b, expected addr=0001 last=1", get_addr(3), last[3]);
    end
    $display("overflow: step addr=%h", get_addr(3));
    step_en[3] = 1'b1; tick();
    checks++;
    if (get_addr(3) !== 'h3FFE || wrap[3] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_wrap: addr=%h wrap=%b, expected addr=3ffe wrap=1", get_addr(3), wrap[3]);
    end
  endtask

  task automatic rand_cfg(input int c);
    set_cfg(c, int'($urandom_range(0, AMASK)), int'($urandom_range(0, AMASK)),
            int'($urandom_range(0, AMASK)), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 4)));
  endtask

  task automatic test_random();
    int errs_before = errors;
    for (int c = 0; c < NUM_CH; c++) begin
      rand_cfg(c);
      cfg_load[c] = 1'b1;
    end
    tick();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        checks++;
        if (get_addr(c) !== m_addr[c] || last[c] !== model_last(c) || wrap[c] !== m_wrap[c]) begin
          errors++;
          $display("FAIL rand ch%0d cyc%0d: addr=%h last=%b wrap=%b, expected addr=%h last=%b wrap=%b",
                   c, cyc, get_addr(c), last[c], wrap[c], m_addr[c], model_last(c), m_wrap[c]);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 15) == 0) begin
          rand_cfg(c);
          cfg_load[c] = 1'b1;
        end
        jump_en[c] = ($urandom_range(0, 7) == 0);
        step_en[c] = ($urandom_range(0, 1) == 1);
        jump_off[c*AW +: AW] = AW'($urandom_range(0, AMASK));
      end
      tick();
    end
    $display("random: 1500 cycles, %0d errors", errors - errs_before);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_1d();
    test_2d();
    test_priority();
    test_overflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
